// File: rtl/writeback_control_pkg.sv
// writeback_control_pkg: ece350 ISA constants, rstatus codes and the writeback
// record shared by the decode and multdiv tracking logic.
package writeback_control_pkg;
   localparam logic [4:0] OP_R = 5'b00000;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_LW = 5'b01000;
   localparam logic [4:0] OP_JAL = 5'b00011;
   localparam logic [4:0] OP_SETX = 5'b10101;
   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_MUL = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;
   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RSTATUS = 5'd30;
   localparam logic [4:0] REG_LINK = 5'd31;
   localparam logic [31:0] RS_ADD = 32'd1;
   localparam logic [31:0] RS_ADDI = 32'd2;
   localparam logic [31:0] RS_SUB = 32'd3;
   localparam logic [31:0] RS_MUL = 32'd4;
   localparam logic [31:0] RS_DIV = 32'd5;
   typedef enum logic {IDLE, WAIT} md_state_t;
   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;
   // Zero means the instruction has no overflow exception path
   function automatic logic [31:0] ovf_code(input logic [4:0] op, input logic [4:0] alu_op);
      return op == OP_ADDI ? RS_ADDI : op != OP_R ? 32'd0 :
             alu_op == ALU_ADD ? RS_ADD : alu_op == ALU_SUB ? RS_SUB : 32'd0;
   endfunction
endpackage

// File: rtl/writeback_control_md_tracker.sv
// md_tracker: IDLE/WAIT tracking of one outstanding mul/div, its rd and kind.
module md_tracker
   import writeback_control_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       issue,
   input  logic       issue_div,
   input  logic [4:0] issue_rd,
   input  logic       md_ready,
   output logic       done,
   output logic       done_div,
   output logic [4:0] done_rd,
   output logic       md_busy
);
   md_state_t state;
   assign done = (state == WAIT) & md_ready;
   assign md_busy = (state == WAIT) & ~md_ready;
   // An issue is only accepted when not stalled, which includes the md_ready cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         done_rd <= '0;
         done_div <= 1'b0;
      end else if (issue & ~md_busy) begin
         state <= WAIT;
         done_rd <= issue_rd;
         done_div <= issue_div;
      end else if (done) begin
         state <= IDLE;
      end
   end
endmodule

// File: rtl/writeback_control.sv
// writeback_control: selects the register-file write for the retiring instruction
// or a completed multdiv, with overflow/exception redirects to $30.
module writeback_control
   import writeback_control_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] insn,
   input  logic        insn_valid,
   input  logic [31:0] alu_result,
   input  logic        alu_ovf,
   input  logic [31:0] mem_data,
   input  logic [31:0] pc_plus1,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_ready,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [31:0] data_writeReg,
   output logic        md_busy
);
   logic [4:0] op, rd, alu_op, done_rd;
   logic is_md, md_done, done_div;
   logic [31:0] rs;
   wb_t nxt;
   assign op = insn[31:27];
   assign rd = insn[26:22];
   assign alu_op = insn[6:2];
   assign is_md = (op == OP_R) & ((alu_op == ALU_MUL) | (alu_op == ALU_DIV));
   assign rs = ovf_code(op, alu_op);
   md_tracker u_md (
      .clk,
      .rst,
      .issue(insn_valid & is_md),
      .issue_div(alu_op == ALU_DIV),
      .issue_rd(rd),
      .md_ready,
      .done(md_done),
      .done_div,
      .done_rd,
      .md_busy
   );
   // A completing multdiv takes priority over anything retiring alongside it
   always_comb begin
      nxt = '0;
      if (md_done)
         nxt = md_exception ? wb_t'{1'b1, REG_RSTATUS, done_div ? RS_DIV : RS_MUL}
                            : wb_t'{1'b1, done_rd, md_result};
      else if (insn_valid & (((op == OP_R) & ~is_md) | (op == OP_ADDI)))
         nxt = (alu_ovf & (rs != 32'd0)) ? wb_t'{1'b1, REG_RSTATUS, rs}
                                         : wb_t'{1'b1, rd, alu_result};
      else if (insn_valid & (op == OP_LW))
         nxt = wb_t'{1'b1, rd, mem_data};
      else if (insn_valid & (op == OP_JAL))
         nxt = wb_t'{1'b1, REG_LINK, pc_plus1};
      else if (insn_valid & (op == OP_SETX))
         nxt = wb_t'{1'b1, REG_RSTATUS, {5'd0, insn[26:0]}};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_writeEnable <= 1'b0;
         ctrl_writeReg <= '0;
         data_writeReg <= '0;
      end else begin
         ctrl_writeEnable <= nxt.we & (nxt.rd != REG_ZERO);
         ctrl_writeReg <= nxt.rd;
         data_writeReg <= nxt.data;
      end
   end
endmodule

// File: tb/tb_writeback_control.sv
// tb_writeback_control: vector table, directed multdiv sequences and a randomized
// stream checked against an opcode-level reference model.
module tb_writeback_control;
   logic clk = 0, rst = 1;
   logic [31:0] insn = 0, alu_result = 0, mem_data = 0, pc_plus1 = 0, md_result = 0;
   logic insn_valid = 0, alu_ovf = 0, md_exception = 0, md_ready = 0;
   logic ctrl_writeEnable, md_busy;
   logic [4:0] ctrl_writeReg;
   logic [31:0] data_writeReg;
   int n_cmp = 0, n_bad = 0;

   writeback_control dut (
      .clk(clk), .rst(rst), .insn(insn), .insn_valid(insn_valid), .alu_result(alu_result),
      .alu_ovf(alu_ovf), .mem_data(mem_data), .pc_plus1(pc_plus1), .md_result(md_result),
      .md_exception(md_exception), .md_ready(md_ready), .ctrl_writeEnable(ctrl_writeEnable),
      .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg), .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      logic [31:0] insn;
      logic        v;
      logic [31:0] alu;
      logic        ovf;
      logic [31:0] mem;
      logic [31:0] pc;
      logic        we;
      logic [4:0]  r;
      logic [31:0] d;
   } vec_t;
   vec_t tbl[$];

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] fn);
      return {op, rd, 15'd0, fn, 2'd0};
   endfunction

   function automatic vec_t mkv(input logic [31:0] i, input logic v, input logic [31:0] alu,
                                input logic ovf, input logic [31:0] mem, input logic [31:0] pc,
                                input logic we, input logic [4:0] r, input logic [31:0] d);
      vec_t x;
      x.insn = i; x.v = v; x.alu = alu; x.ovf = ovf; x.mem = mem; x.pc = pc;
      x.we = we; x.r = r; x.d = d;
      return x;
   endfunction

   // Reference: what the ISA says a single retiring instruction writes
   function automatic logic [37:0] ref_wb(input logic [31:0] i, input logic v, input logic [31:0] alu,
                                          input logic ovf, input logic [31:0] mem, input logic [31:0] pc);
      int op, fn;
      int r;
      logic [31:0] d;
      op = int'(i[31:27]);
      fn = int'(i[6:2]);
      r = -1;
      d = 0;
      if (!v) return 38'd0;
      if (op == 0 && fn != 6 && fn != 7) begin
         r = int'(i[26:22]); d = alu;
         if (ovf && fn == 0) begin r = 30; d = 1; end
         if (ovf && fn == 1) begin r = 30; d = 3; end
      end else if (op == 5) begin
         r = ovf ? 30 : int'(i[26:22]); d = ovf ? 32'd2 : alu;
      end else if (op == 8) begin
         r = int'(i[26:22]); d = mem;
      end else if (op == 3) begin
         r = 31; d = pc;
      end else if (op == 21) begin
         r = 30; d = i & 32'h07FF_FFFF;
      end
      if (r <= 0) return 38'd0;
      return {1'b1, 5'(r), d};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wb(input string name, input logic we, input logic [4:0] r, input logic [31:0] d);
      n_cmp++;
      if (ctrl_writeEnable !== we || (we && (ctrl_writeReg !== r || data_writeReg !== d))) begin
         n_bad++;
         $display("FAIL %s: got we=%0b reg=%0d data=%h, want we=%0b reg=%0d data=%h",
                  name, ctrl_writeEnable, ctrl_writeReg, data_writeReg, we, r, d);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   task automatic issue_md(input logic [4:0] rd, input logic div);
      insn = mk(5'd0, rd, div ? 5'd7 : 5'd6);
      insn_valid = 1;
      tick();
      insn_valid = 0;
   endtask

   initial begin
      logic [4:0] ops[11];
      logic [37:0] e;
      logic [4:0] rr;
      logic dv, ex;
      logic [31:0] res;
      ops = '{5'd0, 5'd5, 5'd7, 5'd8, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd22, 5'd21};

      tick(); tick();
      n_cmp++;
      if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_busy} !== 39'd0) begin
         n_bad++;
         $display("FAIL reset: got we=%0b reg=%0d data=%h busy=%0b, want all zero",
                  ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_busy);
      end
      rst = 0;

      tbl.push_back(mkv(mk(5'd5, 5'd5, 5'd0), 1, 32'h10, 0, 0, 0, 1, 5'd5, 32'h10));
      tbl.push_back(mkv(mk(5'd0, 5'd7, 5'd0), 1, 32'h55, 1, 0, 0, 1, 5'd30, 32'd1));
      tbl.push_back(mkv(mk(5'd0, 5'd7, 5'd1), 1, 32'h55, 1, 0, 0, 1, 5'd30, 32'd3));
      tbl.push_back(mkv(mk(5'd5, 5'd7, 5'd0), 1, 32'h55, 1, 0, 0, 1, 5'd30, 32'd2));
      tbl.push_back(mkv(mk(5'd3, 5'd0, 5'd0), 1, 32'h99, 0, 0, 32'h40, 1, 5'd31, 32'h40));
      tbl.push_back(mkv(mk(5'd7, 5'd6, 5'd0), 1, 32'h99, 0, 0, 0, 0, 5'd0, 32'd0));
      tbl.push_back(mkv(mk(5'd5, 5'd0, 5'd0), 1, 32'h99, 0, 0, 0, 0, 5'd0, 32'd0));
      tbl.push_back(mkv(mk(5'd8, 5'd12, 5'd0), 1, 32'h4, 0, 32'hDEADBEEF, 0, 1, 5'd12, 32'hDEADBEEF));
      tbl.push_back(mkv({5'd21, 27'h3FFFFFF}, 1, 0, 0, 0, 0, 1, 5'd30, 32'h03FFFFFF));
      tbl.push_back(mkv(mk(5'd0, 5'd3, 5'd2), 1, 32'hA5, 1, 0, 0, 1, 5'd3, 32'hA5));
      tbl.push_back(mkv(mk(5'd0, 5'd4, 5'd0), 0, 32'h77, 0, 0, 0, 0, 5'd0, 32'd0));
      tbl.push_back(mkv(mk(5'd2, 5'd4, 5'd0), 1, 32'h77, 0, 0, 0, 0, 5'd0, 32'd0));
      tbl.push_back(mkv(mk(5'd22, 5'd4, 5'd0), 1, 32'h77, 0, 0, 0, 0, 5'd0, 32'd0));
      tbl.push_back(mkv(mk(5'd1, 5'd4, 5'd0), 1, 32'h77, 0, 0, 0, 0, 5'd0, 32'd0));
      tbl.push_back(mkv(mk(5'd4, 5'd4, 5'd0), 1, 32'h77, 0, 0, 0, 0, 5'd0, 32'd0));
      tbl.push_back(mkv(mk(5'd6, 5'd4, 5'd0), 1, 32'h77, 0, 0, 0, 0, 5'd0, 32'd0));
      tbl.push_back(mkv(mk(5'd0, 5'd0, 5'd0), 1, 32'h77, 1, 0, 0, 1, 5'd30, 32'd1));
      tbl.push_back(mkv(mk(5'd0, 5'd0, 5'd4), 1, 32'h77, 0, 0, 0, 0, 5'd0, 32'd0));
      foreach (tbl[k]) begin
         insn = tbl[k].insn; insn_valid = tbl[k].v; alu_result = tbl[k].alu;
         alu_ovf = tbl[k].ovf; mem_data = tbl[k].mem; pc_plus1 = tbl[k].pc;
         tick();
         chk_wb($sformatf("vec%0d", k), tbl[k].we, tbl[k].r, tbl[k].d);
      end
      insn_valid = 0; alu_ovf = 0;
      tick();
      chk_wb("idle_after_vec", 0, 0, 0);

      issue_md(5'd9, 0);
      chk_wb("mul_issue_nowrite", 0, 0, 0);
      for (int c = 0; c < 32; c++) begin
         #1 chk_bit($sformatf("mul_busy_c%0d", c), md_busy, 1);
         if (c < 31) tick();
      end
      md_ready = 1; md_result = 32'h1234;
      #1 chk_bit("mul_busy_ready", md_busy, 0);
      tick();
      md_ready = 0;
      chk_wb("mul_write", 1, 5'd9, 32'h1234);
      #1 chk_bit("mul_idle_busy", md_busy, 0);

      issue_md(5'd11, 1);
      tick(); tick();
      md_ready = 1; md_exception = 1; md_result = 32'hFFFF;
      tick();
      md_ready = 0; md_exception = 0;
      chk_wb("div_exc", 1, 5'd30, 32'd5);

      issue_md(5'd4, 0);
      tick();
      rst = 1;
      tick();
      rst = 0;
      #1 chk_bit("rst_wait_busy", md_busy, 0);
      md_ready = 1; md_result = 32'hBAD;
      #1 chk_bit("rst_ready_busy", md_busy, 0);
      tick();
      md_ready = 0;
      chk_wb("rst_ready_nowrite", 0, 0, 0);

      issue_md(5'd3, 1);
      tick();
      md_ready = 1; md_result = 32'hAA;
      insn = mk(5'd0, 5'd12, 5'd6); insn_valid = 1;
      tick();
      md_ready = 0; insn_valid = 0;
      chk_wb("b2b_old_write", 1, 5'd3, 32'hAA);
      #1 chk_bit("b2b_busy", md_busy, 1);
      md_ready = 1; md_result = 32'hBB;
      tick();
      md_ready = 0;
      chk_wb("b2b_new_write", 1, 5'd12, 32'hBB);

      issue_md(5'd8, 0);
      md_ready = 1; md_result = 32'hCC;
      insn = mk(5'd0, 5'd2, 5'd0); insn_valid = 1; alu_result = 32'h11;
      tick();
      md_ready = 0; insn_valid = 0;
      chk_wb("collide_md_wins", 1, 5'd8, 32'hCC);
      tick();
      chk_wb("collide_insn_dropped", 0, 0, 0);

      for (int k = 0; k < 20; k++) begin
         rr = 5'($urandom_range(0, 31)); dv = 1'($urandom); ex = ($urandom_range(0, 3) == 0);
         res = $urandom;
         issue_md(rr, dv);
         chk_wb($sformatf("rmd%0d_nowrite", k), 0, 0, 0);
         for (int w = $urandom_range(0, 4); w > 0; w--) begin
            #1 chk_bit($sformatf("rmd%0d_busy", k), md_busy, 1);
            tick();
         end
         md_ready = 1; md_exception = ex; md_result = res;
         tick();
         md_ready = 0; md_exception = 0;
         if (ex) chk_wb($sformatf("rmd%0d_exc", k), 1, 5'd30, dv ? 32'd5 : 32'd4);
         else chk_wb($sformatf("rmd%0d_res", k), rr != 0, rr, res);
      end

      for (int k = 0; k < 300; k++) begin
         insn = $urandom;
         insn[31:27] = ops[$urandom_range(0, 10)];
         if (insn[31:27] == 5'd0 && (insn[6:2] == 5'd6 || insn[6:2] == 5'd7)) insn[6:2] = 5'd0;
         insn_valid = ($urandom_range(0, 7) != 0);
         alu_ovf = ($urandom_range(0, 3) == 0);
         alu_result = $urandom; mem_data = $urandom; pc_plus1 = $urandom;
         e = ref_wb(insn, insn_valid, alu_result, alu_ovf, mem_data, pc_plus1);
         tick();
         chk_wb($sformatf("rand%0d", k), e[37], e[36:32], e[31:0]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/writeback_control.md
WRITEBACK_CONTROL -- requirements
Module: writeback_control

Interface
REQ-001 The block SHALL use one clock and synchronous, active-high reset, named as the codebase does: clock  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 insn  in  32  instruction retiring from the memory stage (ece350 ISA: opcode [31:27], rd [26:22], ALU op [6:2]).
REQ-003 insn_valid  in  1  insn is a real, non-bubble instruction this cycle.
REQ-004 alu_result  in  32  ALU or address result for insn.
REQ-005 alu_ovf  in  1  overflow flag for insn.
REQ-006 mem_data  in  32  load data for lw.
REQ-007 pc_plus1  in  32  PC+1 of insn, used as the jal link value.
REQ-008 md_result  in  32  multdiv result.
REQ-009 md_exception  in  1  multdiv exception, qualified by md_ready.
REQ-010 md_ready  in  1  multdiv result valid this cycle.
REQ-011 ctrl_writeEnable  out  1  register-file write strobe.
REQ-012 ctrl_writeReg  out  5  register-file write address.
REQ-013 data_writeReg  out  32  register-file write data.
REQ-014 md_busy  out  1  multiply or divide pending; upstream SHALL stall.

Function
REQ-015 All three write outputs SHALL be registered: a qualifying input in cycle N drives the write during cycle N+1, with 1-cycle latency.
REQ-016 Write sources:
- R-type ALU ops other than mul/div, and addi: write rd with alu_result.
- lw (01000): write rd with mem_data.
- jal (00011): write $31 with pc_plus1.
- setx (10101): write $30 with zero-extended insn[26:0].
REQ-017 The following SHALL produce no write: sw, j, bne, blt, jr, bex, and insn_valid=0.
REQ-018 If alu_ovf=1 on add, addi or sub, the block SHALL write $30 instead, with rstatus 1, 2 or 3 respectively.
REQ-019 A write whose target resolves to $0 SHALL be suppressed, with ctrl_writeEnable=0.
REQ-020 Multdiv tracking SHALL use an FSM with states IDLE and WAIT:
- IDLE -> WAIT when insn_valid and the instruction is R-type mul (00110) or div (00111).
- On that transition the block SHALL latch rd and the op kind, and SHALL NOT write in the next cycle.
REQ-021 In WAIT with md_ready=1:
- Next cycle, write the latched rd with md_result.
- If md_exception=1, write $30 with 4 (mul) or 5 (div) instead.
- Return to IDLE.
REQ-022 md_busy SHALL equal (state==WAIT) & ~md_ready, which allows issue in the same cycle md_ready arrives.
REQ-023 Simultaneous md_ready and a valid non-multdiv insn in WAIT is illegal because upstream is stalled. If it occurs, the multdiv write SHALL win and insn SHALL be dropped.
REQ-024 A new mul/div issued in the cycle md_ready=1 SHALL leave the FSM in WAIT with the new rd latched, after the old result is written.

Reset
REQ-025 While reset=1 at a clock edge:
- ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
- FSM=IDLE, latched rd=0, md_busy=0.
REQ-026 Reset during WAIT SHALL abandon the pending result. A later md_ready SHALL be ignored until a new mul/div issues.

Structure
REQ-027 The opcode constants, ALU op codes for add/sub/mul/div, registers $30/$31 and the rstatus codes 1-5 SHALL live in a shared ISA package used by the decode and writeback logic.
REQ-028 The design SHALL contain one sub-module, md_tracker, holding the IDLE/WAIT FSM, the latched rd and op kind, and md_busy.

Verification
REQ-029 The bench SHALL cover at least the following directed scenarios:
- addi rd=5, alu_result=0x10, no ovf -> next cycle: WE=1, reg=5, data=0x10.
- add with ovf=1, rd=7 -> next cycle: WE=1, reg=30, data=1. Same with sub -> data=3.
- jal, pc_plus1=0x40 -> reg=31, data=0x40. sw, and addi rd=0 -> WE=0.
- mul rd=9 issued, md_ready after 32 cycles with md_result=0x1234 -> md_busy high for 32 cycles and low in the md_ready cycle; next cycle WE=1, reg=9, data=0x1234. div with md_exception -> reg=30, data=5.
- reset asserted mid-WAIT, then md_ready pulse -> md_busy=0, no write.
- setx T=0x3FFFFFF -> reg=30, data=0x03FFFFFF.
